// File: rtl/mips_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
// Pure declarations: no timing or flow control of its own.
// Imported by the sequencer and its datapath step.
package mips_pkg;

    localparam int MD_ITER_CNT = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'b00,
        MD_ITER  = 2'b01,
        MD_FIXUP = 2'b10
    } md_state_e;

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared shift/add (multiply) or restoring shift/subtract (divide) datapath.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the result is registered.
module muldiv_step
    import mips_pkg::*;
(
    input  logic [63:0] work_dat,
    input  logic [31:0] opnd_dat,
    input  logic        is_div,
    output logic [63:0] work_nxt
);

    logic [32:0] mul_sum;
    logic [32:0] div_top;
    logic [32:0] div_diff;

    always_comb begin
        mul_sum  = {1'b0, work_dat[63:32]} + {1'b0, opnd_dat};
        // Upper half after the left shift, including the bit shifted out of the top.
        div_top  = work_dat[63:31];
        div_diff = div_top - {1'b0, opnd_dat};
        work_nxt = work_dat;

        if (is_div) begin
            if (div_top >= {1'b0, opnd_dat}) begin
                work_nxt = {div_diff[31:0], work_dat[30:0], 1'b1};
            end else begin
                work_nxt = {work_dat[62:0], 1'b0};
            end
        end else begin
            if (work_dat[0]) begin
                work_nxt = {mul_sum, work_dat[31:1]};
            end else begin
                work_nxt = {1'b0, work_dat[63:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner and 32-step iterative MULT/MULTU/DIV/DIVU sequencer with ID-stage stall request.
// Latency: accept edge + 32 ITER cycles + 1 FIXUP cycle; divide-by-zero skips ITER.
// Backpressure: no handshake; md_stall holds dependent ID instructions, requests while busy are dropped.
module muldiv_sequencer #(
    parameter int ITER = mips_pkg::MD_ITER_CNT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        id_hilo_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
);
    import mips_pkg::*;

    localparam int CW = $clog2(ITER);

    md_state_e     state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   work_q, work_d;
    logic [31:0]   opnd_q, opnd_d;
    logic          is_div_q, is_div_d;
    logic          neg_lo_q, neg_lo_d;
    logic          neg_hi_q, neg_hi_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    md_op_e        op_in;
    logic          is_signed_in;
    logic          is_div_in;
    logic [31:0]   rs_mag;
    logic [31:0]   rt_mag;
    logic [63:0]   step_nxt;

    muldiv_step u_step (
        .work_dat (work_q),
        .opnd_dat (opnd_q),
        .is_div   (is_div_q),
        .work_nxt (step_nxt)
    );

    always_comb begin
        op_in        = md_op_e'(op);
        is_signed_in = (op_in == MD_MULT) || (op_in == MD_DIV);
        is_div_in    = (op_in == MD_DIV) || (op_in == MD_DIVU);
        rs_mag       = md_abs(rs_val, is_signed_in);
        rt_mag       = md_abs(rt_val, is_signed_in);

        state_d  = state_q;
        count_d  = count_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    is_div_d = is_div_in;
                    count_d  = '0;
                    if (is_div_in && (rt_val == 32'd0)) begin
                        // Preload the architectural divide-by-zero result and let FIXUP pass it through untouched.
                        work_d   = {rs_val, 32'hFFFF_FFFF};
                        opnd_d   = 32'd0;
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                        state_d  = MD_FIXUP;
                    end else begin
                        work_d   = {32'd0, is_div_in ? rs_mag : rt_mag};
                        opnd_d   = is_div_in ? rt_mag : rs_mag;
                        neg_lo_d = is_signed_in & (rs_val[31] ^ rt_val[31]);
                        neg_hi_d = is_signed_in & is_div_in & rs_val[31];
                        state_d  = MD_ITER;
                    end
                end else begin
                    if (mthi) hi_d = rs_val;
                    if (mtlo) lo_d = rs_val;
                end
            end

            MD_ITER: begin
                work_d  = step_nxt;
                count_d = count_q + 1'b1;
                if (count_q == CW'(ITER - 1)) begin
                    count_d = '0;
                    state_d = MD_FIXUP;
                end
            end

            MD_FIXUP: begin
                if (is_div_q) begin
                    hi_d = neg_hi_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];
                    lo_d = neg_lo_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? (~work_q + 64'd1) : work_q;
                end
                state_d = MD_IDLE;
            end

            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            count_q  <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != MD_IDLE);
    assign md_stall = busy & id_hilo_use;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: results, cycle timing, stall and reset behaviour.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic        id_hilo_use;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.ITER(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .id_hilo_use (id_hilo_use),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .md_stall    (md_stall)
    );

    // Inputs change and outputs are sampled at the falling edge, in the middle of a cycle.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Called in cycle 0 of an operation; returns in cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        next_cycle();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        id_hilo_use = 1'b1;
        next_cycle();
        next_cycle();
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (md_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", md_stall); end
        reset       = 1'b0;
        id_hilo_use = 1'b0;
        next_cycle();
    endtask

    task automatic test_multu();
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        for (int c = 1; c <= 33; c++) begin
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL multu_busy c%0d: got %b want 1", c, busy); end
            if (c == 33) begin
                n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_bad++; $display("FAIL multu_hold c33: got %h_%h want 0_0", hi, lo); end
            end
            next_cycle();
        end
        n_cmp++; if (hi !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_hi: got %h want 00000001", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL multu_busy c34: got %b want 0", busy); end
    endtask

    task automatic test_mult();
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
        repeat (33) next_cycle();
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
    endtask

    task automatic test_div();
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        repeat (32) next_cycle();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL div_busy c33: got %b want 1", busy); end
        next_cycle();
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        // Back-to-back: next op starts in the same cycle the previous result appears.
        issue(2'b11, 32'h0000_0064, 32'h0000_0007);
        repeat (33) next_cycle();
        n_cmp++; if (lo !== 32'h0000_000E) begin n_bad++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        n_cmp++; if (hi !== 32'h0000_0002) begin n_bad++; $display("FAIL divu_hi: got %h want 00000002", hi); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL divu_busy c34: got %b want 0", busy); end
    endtask

    task automatic test_div_zero();
        issue(2'b11, 32'h1234_5678, 32'h0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dz_busy c1: got %b want 1", busy); end
        n_cmp++; if (lo !== 32'h0000_000E) begin n_bad++; $display("FAIL dz_hold c1: got %h want 0000000e", lo); end
        next_cycle();
        n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dzu_lo: got %h want ffffffff", lo); end
        n_cmp++; if (hi !== 32'h1234_5678) begin n_bad++; $display("FAIL dzu_hi: got %h want 12345678", hi); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dzu_busy c2: got %b want 0", busy); end
        issue(2'b10, 32'h8000_0005, 32'h0);
        next_cycle();
        n_cmp++; if (hi !== 32'h8000_0005) begin n_bad++; $display("FAIL dzs_hi: got %h want 80000005", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dzs_lo: got %h want ffffffff", lo); end
    endtask

    task automatic test_stall();
        id_hilo_use = 1'b1;
        n_cmp++; if (md_stall !== 1'b0) begin n_bad++; $display("FAIL stall_idle: got %b want 0", md_stall); end
        issue(2'b00, 32'h0000_0007, 32'h0000_0006);
        for (int c = 1; c <= 33; c++) begin
            n_cmp++; if (md_stall !== 1'b1) begin n_bad++; $display("FAIL stall_on c%0d: got %b want 1", c, md_stall); end
            next_cycle();
        end
        n_cmp++; if (md_stall !== 1'b0) begin n_bad++; $display("FAIL stall_drop c34: got %b want 0", md_stall); end
        n_cmp++; if (lo !== 32'h0000_002A) begin n_bad++; $display("FAIL stall_lo c34: got %h want 0000002a", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL stall_hi c34: got %h want 00000000", hi); end
        id_hilo_use = 1'b0;
        issue(2'b01, 32'h0000_0003, 32'h0000_0004);
        for (int c = 1; c <= 33; c++) begin
            n_cmp++; if (md_stall !== 1'b0) begin n_bad++; $display("FAIL stall_off c%0d: got %b want 0", c, md_stall); end
            next_cycle();
        end
        n_cmp++; if (lo !== 32'h0000_000C) begin n_bad++; $display("FAIL nostall_lo: got %h want 0000000c", lo); end
    endtask

    task automatic test_busy_ignore();
        issue(2'b01, 32'h0000_000A, 32'h0000_000A);
        repeat (4) next_cycle();
        start  = 1'b1;
        mthi   = 1'b1;
        mtlo   = 1'b1;
        op     = 2'b11;
        rs_val = 32'h0000_0001;
        rt_val = 32'h0000_0001;
        next_cycle();
        start  = 1'b0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0000_000C) begin n_bad++; $display("FAIL busy_mt: got %h_%h want 00000000_0000000c", hi, lo); end
        repeat (28) next_cycle();
        n_cmp++; if (lo !== 32'h0000_0064) begin n_bad++; $display("FAIL busy_ign_lo: got %h want 00000064", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL busy_ign_hi: got %h want 00000000", hi); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_ign_busy: got %b want 0", busy); end
    endtask

    task automatic test_mt();
        mthi   = 1'b1;
        rs_val = 32'hCAFE_0001;
        next_cycle();
        mthi   = 1'b0;
        n_cmp++; if (hi !== 32'hCAFE_0001) begin n_bad++; $display("FAIL mthi: got %h want cafe0001", hi); end
        n_cmp++; if (lo !== 32'h0000_0064) begin n_bad++; $display("FAIL mthi_lo: got %h want 00000064", lo); end
        mthi = 1'b1;
        issue(2'b01, 32'h0000_0002, 32'h0000_0003);
        mthi = 1'b0;
        n_cmp++; if (hi !== 32'hCAFE_0001) begin n_bad++; $display("FAIL mt_prio c1: got %h want cafe0001", hi); end
        repeat (33) next_cycle();
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL mt_prio_hi: got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h0000_0006) begin n_bad++; $display("FAIL mt_prio_lo: got %h want 00000006", lo); end
    endtask

    task automatic test_reset_mid();
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        repeat (9) next_cycle();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy c10: got %b want 1", busy); end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy c11: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rmid_hi: got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL rmid_lo: got %h want 00000000", lo); end
        mtlo   = 1'b1;
        rs_val = 32'h0000_ABCD;
        next_cycle();
        mtlo   = 1'b0;
        n_cmp++; if (lo !== 32'h0000_ABCD) begin n_bad++; $display("FAIL rmid_mtlo: got %h want 0000abcd", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rmid_mtlo_hi: got %h want 00000000", hi); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_mtlo_busy: got %b want 0", busy); end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        op          = 2'b00;
        rs_val      = 32'h0;
        rt_val      = 32'h0;
        mthi        = 1'b0;
        mtlo        = 1'b0;
        id_hilo_use = 1'b0;
        next_cycle();
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_busy_ignore();
        test_mt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
